// File: rtl/dsn_spike_decoder.sv
// dsn_spike_decoder: rebuilds the mean 8-bit vpre from a DSN spike train over 2^WIN_LOG2-cycle windows.
// Define DSN_DEC_ROUND_EN for round-half-up instead of truncation.
module dsn_spike_decoder #(
  parameter int WIN_LOG2 = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en,
  input  logic                spike,
  input  logic [12:0]         vth,
  input  logic [7:0]          leak,
  output logic [7:0]          vout,
  output logic                valid,
  output logic                sat,
  output logic [WIN_LOG2:0]   spike_count,
  output logic [WIN_LOG2-1:0] win_pos
);
  localparam int AW = 15 + WIN_LOG2;
  localparam int CW = WIN_LOG2 + 1;
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state, state_n;
  logic [AW-1:0] acc, sum;
  logic [CW-1:0] cnt;
  logic [13:0] inc;
  logic [14:0] res;
  logic last, clip, run;
  always_comb begin
    state_n = en ? ACCUM : IDLE;
    inc = 14'(spike ? vth : 13'd0) + 14'(leak);
    sum = acc + AW'(inc);
`ifdef DSN_DEC_ROUND_EN
    res = 15'((sum + AW'(1 << (WIN_LOG2 - 1))) >> WIN_LOG2);
`else
    res = 15'(sum >> WIN_LOG2);
`endif
    clip = |res[14:8];
    last = state == ACCUM && en && &win_pos;
    run = state == ACCUM && en && !last;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // Any edge that is not a mid-window sample (idle, abort, window end) restarts the window.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      acc <= '0;
      cnt <= '0;
      win_pos <= '0;
      vout <= '0;
      valid <= 1'b0;
      sat <= 1'b0;
      spike_count <= '0;
    end else begin
      valid <= last;
      if (last) begin
        vout <= clip ? 8'hff : res[7:0];
        sat <= clip;
        spike_count <= cnt + CW'(spike);
      end
      if (run) begin
        acc <= sum;
        cnt <= cnt + CW'(spike);
        win_pos <= win_pos + WIN_LOG2'(1);
      end else begin
        acc <= '0;
        cnt <= '0;
        win_pos <= '0;
      end
    end
endmodule

// File: tb/tb_dsn_spike_decoder.sv
// tb_dsn_spike_decoder: table-driven window checks plus abort and async-reset sequences.
module tb_dsn_spike_decoder;
  logic clock = 1'b0, reset = 1'b1, en = 1'b0, spike = 1'b0;
  logic [12:0] vth = '0;
  logic [7:0] leak = '0;
  logic [7:0] vout;
  logic valid, sat;
  logic [3:0] spike_count;
  logic [2:0] win_pos;
  int n_cmp = 0, n_bad = 0;

  typedef struct {
    logic [12:0] vth;
    logic [7:0]  leak;
    logic [7:0]  pat;
    logic [7:0]  v;
    logic        s;
    logic [3:0]  c;
  } vec_t;
  vec_t tv[12];

  dsn_spike_decoder #(.WIN_LOG2(3)) dut (
    .clock(clock), .reset(reset), .en(en), .spike(spike), .vth(vth), .leak(leak),
    .vout(vout), .valid(valid), .sat(sat), .spike_count(spike_count), .win_pos(win_pos)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic e, input logic s);
    en = e;
    spike = s;
    @(posedge clock);
    #1;
  endtask

  task automatic window(input string tag, input vec_t t, input bit from_idle);
    vth = t.vth;
    leak = t.leak;
    if (from_idle) begin
      step(1'b1, 1'b0);
      chk({tag, " start valid"}, int'(valid), 0);
      chk({tag, " start win_pos"}, int'(win_pos), 0);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, t.pat[i]);
      if (i < 7) begin
        chk($sformatf("%s valid@%0d", tag, i), int'(valid), 0);
        chk($sformatf("%s win_pos@%0d", tag, i), int'(win_pos), i + 1);
      end else begin
        chk({tag, " valid"}, int'(valid), 1);
        chk({tag, " vout"}, int'(vout), int'(t.v));
        chk({tag, " sat"}, int'(sat), int'(t.s));
        chk({tag, " spike_count"}, int'(spike_count), int'(t.c));
        chk({tag, " win_pos wrap"}, int'(win_pos), 0);
      end
    end
  endtask

  initial begin
    tv[0]  = '{13'd32,   8'd2,   8'hff, 8'd34,  1'b0, 4'd8};
    tv[1]  = '{13'd32,   8'd2,   8'hff, 8'd34,  1'b0, 4'd8};
    tv[2]  = '{13'd32,   8'd2,   8'h55, 8'd18,  1'b0, 4'd4};
    tv[3]  = '{13'd16,   8'd0,   8'h15, 8'd6,   1'b0, 4'd3};
    tv[4]  = '{13'd16,   8'd0,   8'h0a, 8'd4,   1'b0, 4'd2};
`ifdef DSN_DEC_ROUND_EN
    tv[5]  = '{13'd13,   8'd0,   8'h15, 8'd5,   1'b0, 4'd3};
    tv[10] = '{13'd4,    8'd255, 8'h01, 8'd255, 1'b1, 4'd1};
`else
    tv[5]  = '{13'd13,   8'd0,   8'h15, 8'd4,   1'b0, 4'd3};
    tv[10] = '{13'd4,    8'd255, 8'h01, 8'd255, 1'b0, 4'd1};
`endif
    tv[6]  = '{13'd8191, 8'd255, 8'hff, 8'd255, 1'b1, 4'd8};
    tv[7]  = '{13'd8191, 8'd0,   8'h00, 8'd0,   1'b0, 4'd0};
    tv[8]  = '{13'd100,  8'd10,  8'h81, 8'd35,  1'b0, 4'd2};
    tv[9]  = '{13'd0,    8'd255, 8'hff, 8'd255, 1'b0, 4'd8};
    tv[11] = '{13'd8191, 8'd255, 8'h01, 8'd255, 1'b1, 4'd1};

    repeat (2) @(posedge clock);
    #1;
    chk("reset vout", int'(vout), 0);
    chk("reset valid", int'(valid), 0);
    chk("reset sat", int'(sat), 0);
    chk("reset spike_count", int'(spike_count), 0);
    chk("reset win_pos", int'(win_pos), 0);
    reset = 1'b0;
    step(1'b0, 1'b1);
    chk("idle valid", int'(valid), 0);
    chk("idle win_pos", int'(win_pos), 0);

    for (int k = 0; k < 12; k++) window($sformatf("vec%0d", k), tv[k], k == 0);

    vth = 13'd32;
    leak = 8'd2;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1);
      chk($sformatf("pre-abort win_pos@%0d", i), int'(win_pos), i + 1);
    end
    step(1'b0, 1'b1);
    chk("abort valid", int'(valid), 0);
    chk("abort win_pos", int'(win_pos), 0);
    chk("abort vout hold", int'(vout), 255);
    chk("abort sat hold", int'(sat), 1);
    chk("abort count hold", int'(spike_count), 1);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1);
      chk("idle after abort valid", int'(valid), 0);
      chk("idle after abort win_pos", int'(win_pos), 0);
    end
    window("re-enable", tv[0], 1'b1);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    chk("pre-reset win_pos", int'(win_pos), 3);
    #3 reset = 1'b1;
    #1;
    chk("async reset vout", int'(vout), 0);
    chk("async reset valid", int'(valid), 0);
    chk("async reset sat", int'(sat), 0);
    chk("async reset spike_count", int'(spike_count), 0);
    chk("async reset win_pos", int'(win_pos), 0);
    #2 reset = 1'b0;
    window("post-reset", tv[2], 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
